// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared FSM state type and terminal-flag selection for counter_sched.
package counter_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  // Terminal flag for the job direction: max_count when counting up, zero when counting down.
  function automatic logic term_hit(input logic up, input logic zero, input logic max_count);
    return up ? max_count : zero;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit starting at ptr.
// Ports: req (request vector), ptr (search start), enable (gates the pick),
//        gnt (one-hot winner, 0 if none/disabled), idx (encoded winner, 0 if none).
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic          found;
  logic [IW-1:0] p;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    p = '0;
    for (int k = 0; k < N; k++) begin
      p = IW'((int'(ptr) + k) % N);
      if (enable && !found && req[p]) begin
        found = 1'b1;
        gnt[p] = 1'b1;
        idx = p;
      end
    end
  end
endmodule

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one up/down counter among NUM_REQ requesters.
// Ports: clk, rst_n (async active-low); req/req_load/req_dir (per-requester job requests);
//        grant/done/busy (to requesters); load_n/data_load/ce/up_down (counter controls);
//        zero/max_count (counter terminal flags).
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_load,
  input  logic [NUM_REQ-1:0]       req_dir,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     load_n,
  output logic [WIDTH-1:0]         data_load,
  output logic                     ce,
  output logic                     up_down,
  input  logic                     zero,
  input  logic                     max_count
);
  localparam int IW = $clog2(NUM_REQ);
  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, owner, pick_idx, ptr_nxt;
  logic [NUM_REQ-1:0]  pick;
  logic                term, abort;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(ptr),
    .enable(state == IDLE),
    .gnt(pick),
    .idx(pick_idx)
  );
  assign term = term_hit(up_down, zero, max_count);
  // Owner withdrawing its request before completion cancels the job without a done pulse.
  assign abort = (state == LOAD || state == RUN) && !req[owner];
  assign ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE) ? (|req ? LOAD : IDLE) :
                (state == DONE || abort) ? IDLE :
                (state == LOAD) ? RUN :
                (term ? DONE : RUN);
  end
  always_comb begin
    busy = state != IDLE;
    load_n = state != LOAD;
    ce = state == RUN && !term && !abort;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      done <= '0;
      data_load <= '0;
      up_down <= 1'b0;
      ptr <= '0;
      owner <= '0;
    end else begin
      done <= (state == RUN && term && !abort) ? grant : '0;
      if (state == IDLE && |req) begin
        grant <= pick;
        owner <= pick_idx;
        data_load <= req_load[int'(pick_idx)*WIDTH +: WIDTH];
        up_down <= req_dir[pick_idx];
      end else if (state == DONE || abort) begin
        grant <= '0;
        ptr <= ptr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: randomized and directed checking of counter_sched against a job-level timing model.
module tb_counter_sched;
  localparam int W = 4;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_dir = '0;
  logic [N*W-1:0] req_load = '0;
  logic [N-1:0] grant, done;
  logic busy, load_n, ce, up_down, zero, max_count;
  logic [W-1:0] data_load;
  logic [W-1:0] cnt = '0;
  int n_tests = 0;
  int n_fail = 0;
  int m_own = -1;
  int m_ptr = 0;
  int m_d = 0;
  int m_r = 0;
  int m_l = 0;
  int m_dir = 0;

  counter_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_load(req_load), .req_dir(req_dir),
    .grant(grant), .done(done), .busy(busy), .load_n(load_n), .data_load(data_load),
    .ce(ce), .up_down(up_down), .zero(zero), .max_count(max_count)
  );

  always #5 clk = ~clk;

  // External counter the scheduler drives.
  always @(posedge clk)
    if (!load_n) cnt <= data_load;
    else if (ce) cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
  assign zero = cnt == '0;
  assign max_count = &cnt;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Job-level model: a job granted at cycle t0 loads at t0+1, counts from t0+2 for R
  // cycles (R = distance to the terminal value), and pulses done at t0+3+R.
  task automatic model_and_check();
    int e_grant, e_done, e_busy, e_load_n, e_ce;
    bit ab;
    e_grant = 0; e_done = 0; e_busy = 0; e_load_n = 1; e_ce = 0;
    if (!rst_n) begin
      m_own = -1;
      m_ptr = 0;
      check("rst_data_load", int'(data_load), 0);
      check("rst_up_down", int'(up_down), 0);
    end else if (m_own >= 0) begin
      m_d++;
      e_busy = 1;
      e_grant = 1 << m_own;
      e_load_n = (m_d == 1) ? 0 : 1;
      ab = (m_d <= 2 + m_r) && !req[m_own];
      e_ce = (m_d >= 2 && m_d < 2 + m_r && !ab) ? 1 : 0;
      e_done = (m_d == 3 + m_r) ? e_grant : 0;
      check("data_load", int'(data_load), m_l);
      check("up_down", int'(up_down), m_dir);
      if (ab || m_d == 3 + m_r) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
    end else if (|req) begin
      for (int k = 0; k < N; k++)
        if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      m_d = 0;
      m_l = int'(req_load[m_own*W +: W]);
      m_dir = int'(req_dir[m_own]);
      m_r = m_dir != 0 ? (2**W - 1 - m_l) : m_l;
    end
    check("grant", int'(grant), e_grant);
    check("done", int'(done), e_done);
    check("busy", int'(busy), e_busy);
    check("load_n", int'(load_n), e_load_n);
    check("ce", int'(ce), e_ce);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      model_and_check();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_job(input int i, input int l, input int d);
    req_load[i*W +: W] = W'(l);
    req_dir[i] = d[0];
  endtask

  initial begin
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    set_job(0, 3, 0); req = 4'b0001; cyc(7); req = '0; cyc(2);
    set_job(2, 13, 1); req = 4'b0100; cyc(6); req = '0; cyc(2);
    set_job(3, 0, 0); req = 4'b1000; cyc(4); req = '0; cyc(2);
    set_job(0, 15, 1); req = 4'b0001; cyc(4); req = '0; cyc(2);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_job(i, 1, 0);
    req = 4'b1111; cyc(26); req = '0; cyc(2);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    set_job(0, 0, 0); req = 4'b0001; cyc(4); req = '0; cyc(2);
    set_job(1, 5, 0); set_job(2, 2, 0); req = 4'b0110; cyc(3);
    req = 4'b0100; cyc(8); req = '0; cyc(2);
    set_job(3, 7, 0); req = 4'b1000; cyc(4);
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_ce", int'(ce), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_load_n", int'(load_n), 1);
    check("async_rst_busy", int'(busy), 0);
    set_job(0, 2, 0); req = 4'b1001;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check("post_rst_grant", int'(grant), 1);
    cyc(8); req = '0; cyc(2);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && $urandom_range(39) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
        if ($urandom_range(7) == 0) set_job(i, int'($urandom_range(2**W - 1)), int'($urandom_range(1)));
      end
      cyc(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler sharing one WIDTH-bit up/down counter (load/ce/up_down datapath) among NUM_REQ requesters.
- Each requester asks for a timed job: start value plus direction. The block arbitrates, loads the counter and enables counting until the terminal flag (zero for down, max_count for up). It then pulses done to the owner and releases the counter.
- Sits between the requesting blocks and the counter instance, driving all of the counter's control inputs.

Parameters:
- WIDTH, 4, counter width; must match the counter instance.
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  level request per requester
- req_load  input  NUM_REQ*WIDTH  start value; requester i at bits [i*WIDTH +: WIDTH]
- req_dir  input  NUM_REQ  1 = count up, 0 = count down
- grant  output  NUM_REQ  one-hot owner, held LOAD through DONE
- done  output  NUM_REQ  one-cycle completion pulse to owner
- busy  output  1  high when state != IDLE
- load_n  output  1  to counter, active-low load
- data_load  output  WIDTH  to counter, load value
- ce  output  1  to counter, count enable
- up_down  output  1  to counter, direction
- zero  input  1  from counter
- max_count  input  1  from counter

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, done=0, busy=0, load_n=1, ce=0, data_load=0, up_down=0, priority pointer ptr=0.
  - Counter reset is not driven by this block.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req bit set, pick the first set bit searching ptr, ptr+1, ... mod NUM_REQ.
  - Register grant and capture that requester's req_load into data_load and req_dir into up_down.
  - Go to LOAD. No request: stay in IDLE.
- LOAD (exactly 1 cycle): load_n=0, ce=0; go to RUN.
- RUN:
  - term = up_down ? max_count : zero, evaluated combinationally each cycle.
  - ce = !term, so ce is never high in a cycle where term=1.
  - term=1 -> go to DONE.
- DONE (1 cycle): done[owner]=1 (registered pulse), grant still held. Next cycle: grant=0, ptr=owner+1 mod NUM_REQ, go to IDLE.
- Outputs: load_n and ce are combinational from state/term. data_load and up_down are registered and stable for the whole job.
- Latency (t0 = IDLE cycle in which arbitration occurs):
  - LOAD at t0+1; RUN begins t0+2 with count_out = start value L.
  - Down job: done pulses at t0+3+L.
  - Up job: done pulses at t0+3+(2^WIDTH-1-L).
- L already terminal (L=0 down, or L=all-ones up): RUN lasts 1 cycle with ce=0; done at t0+3.
- Abort: owner's req falls during LOAD or RUN:
  - ce=0 that cycle; next cycle go to IDLE, grant=0, ptr=owner+1.
  - No done pulse.
- req falling in DONE is not an abort; done still pulses.
- Inputs are sampled only at arbitration. Changes to req_load/req_dir mid-job are ignored.
- Non-owner req bits are ignored while busy.
- A requester holding req after done competes again; it is served only after every other pending requester (fairness).
- Minimum gap between jobs: 1 IDLE cycle.
- Reset mid-job: immediate return to reset values; any partial job is lost, no done pulse.

Decomposition:
- Package counter_sched_pkg: state enum (IDLE, LOAD, RUN, DONE) and a function giving the terminal value per direction.
- One sub-module, rr_arbiter: NUM_REQ-wide, inputs req, ptr, enable; output one-hot gnt and encoded index. Purely combinational pick; ptr register lives in counter_sched.

Test Plan:
- Single down job: req[0]=1, req_load[0]=3, dir=0 from IDLE.
  - Expect grant=4'b0001, load_n=0 at t0+1, count 3,2,1,0, ce low at count 0.
  - Expect done[0] pulse at t0+6.
- Up job, WIDTH=4: req[2]=1, load=13, dir=1.
  - Expect count 13,14,15, done[2] at t0+5, ce=0 while max_count=1.
- Immediate terminal: load=0 dir=0 (and load=15 dir=1).
  - Expect ce never asserted, done at t0+3.
- Contention: all four req held with load=1 dir=0.
  - Expect grants 0,1,2,3,0 in order, each done one IDLE cycle before the next grant.
  - Expect no grant overlap.
- Abort: req[1] dropped at 2nd RUN cycle of load=5 down job.
  - Expect ce=0 that cycle, no done[1], next winner is requester 2 if requesting.
- Reset mid-RUN: assert rst_n=0 asynchronously.
  - Expect grant/ce/done to 0 and load_n=1 before the next clk edge.
  - After release, expect ptr=0 (req[3] and req[0] both high -> grant 0).
